// File: rtl/decoder_pkg.sv
// Shared types and the select-to-one-hot decode used by the 2-to-4 decoder.
package decoder_pkg;

  typedef logic [1:0] dec_sel_t;
  typedef logic [3:0] dec_onehot_t;

  localparam dec_onehot_t DEC_IDLE = 4'b0000;

  function automatic dec_onehot_t onehot_decode(input dec_sel_t sel);
    return dec_onehot_t'(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/decoder_2x4_comb.sv
// Pure combinational 2-bit select to 4-bit one-hot decode.
module decoder_2x4_comb
  import decoder_pkg::*;
(
  input  dec_sel_t    sel,
  output dec_onehot_t dec
);

  assign dec = onehot_decode(sel);

endmodule

// File: rtl/decoder_2x4_sync.sv
// Registered 2-to-4 decoder: one cycle of latency, optional active-low outputs.
module decoder_2x4_sync
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit RESET_VAL_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  localparam dec_onehot_t IDLE_CODE = OUT_ACTIVE_LOW ? ~DEC_IDLE : DEC_IDLE;

  dec_onehot_t dec;
  dec_onehot_t dec_q;
  logic        valid_q;

  decoder_2x4_comb u_comb (
    .sel ({a, b}),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst && RESET_VAL_EN) begin
      dec_q <= IDLE_CODE;
    end else begin
      dec_q <= OUT_ACTIVE_LOW ? ~dec : dec;
    end
    // Marks that dec_q holds a decoded value rather than the idle code.
    valid_q <= !rst;
  end

  assign {y3, y2, y1, y0} = dec_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    valid_q |-> $onehot(OUT_ACTIVE_LOW ? ~dec_q : dec_q));

endmodule

// File: tb/tb_decoder_2x4_sync.sv
// Randomized self-checking bench for decoder_2x4_sync, both output polarities.
module tb_decoder_2x4_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic h0, h1, h2, h3;
  logic l0, l1, l2, l3;
  logic [3:0] y_h, y_l;
  logic [3:0] model;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_2x4_sync #(.OUT_ACTIVE_LOW(1'b0), .RESET_VAL_EN(1'b1)) dut_h (
    .clk(clk), .rst(rst), .a(a), .b(b), .y0(h0), .y1(h1), .y2(h2), .y3(h3)
  );

  decoder_2x4_sync #(.OUT_ACTIVE_LOW(1'b1), .RESET_VAL_EN(1'b1)) dut_l (
    .clk(clk), .rst(rst), .a(a), .b(b), .y0(l0), .y1(l1), .y2(l2), .y3(l3)
  );

  assign y_h = {h3, h2, h1, h0};
  assign y_l = {l3, l2, l1, l0};

  // Drive inputs mid-cycle, clock once, update the reference, settle.
  task automatic step(input logic r, input logic ia, input logic ib);
    int idx;
    @(negedge clk);
    rst = r; a = ia; b = ib;
    @(posedge clk);
    idx = int'(ia) * 2 + int'(ib);
    model = r ? 4'b0000 : 4'(1 << idx);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (y_h !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hi cycle %0d: got %b want 0000", i, y_h);
      end
      checks++;
      if (y_l !== 4'b1111) begin
        failures++;
        $display("FAIL reset_lo cycle %0d: got %b want 1111", i, y_l);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] table_exp [4];
    logic [1:0] s;
    table_exp[0] = 4'b0001; table_exp[1] = 4'b0010;
    table_exp[2] = 4'b0100; table_exp[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      step(1'b0, s[1], s[0]);
      checks++;
      if (y_h !== table_exp[i]) begin
        failures++;
        $display("FAIL sweep_hi sel=%0d: got %b want %b", i, y_h, table_exp[i]);
      end
      checks++;
      if (y_l !== ~model) begin
        failures++;
        $display("FAIL sweep_lo sel=%0d: got %b want %b", i, y_l, ~model);
      end
    end
  endtask

  task automatic test_latency();
    step(1'b0, 1'b0, 1'b0);
    #2; a = 1'b1; b = 1'b1;
    #2;
    checks++;
    if (y_h !== 4'b0001) begin
      failures++;
      $display("FAIL latency_mid: got %b want 0001", y_h);
    end
    #2; a = 1'b0; b = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (y_h !== 4'b0001) begin
      failures++;
      $display("FAIL latency_edge: got %b want 0001", y_h);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (y_h !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_before: got %b want 0100", y_h);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (y_h !== 4'b0000 || y_l !== 4'b1111) begin
      failures++;
      $display("FAIL rstmid_held: got %b/%b want 0000/1111", y_h, y_l);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (y_h !== 4'b0100 || y_l !== 4'b1011) begin
      failures++;
      $display("FAIL rstmid_after: got %b/%b want 0100/1011", y_h, y_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 1'b1);
      else            step(1'b0, 1'b1, 1'b0);
      want = (i % 2 == 0) ? 4'b0010 : 4'b0100;
      checks++;
      if (y_h !== want || y_h !== model) begin
        failures++;
        $display("FAIL b2b cycle %0d: got %b want %b", i, y_h, want);
      end
    end
  endtask

  task automatic test_random();
    logic r, ia, ib;
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(99) < 5);
      ia = 1'($urandom);
      ib = 1'($urandom);
      step(r, ia, ib);
      checks++;
      if (y_h !== model || y_l !== ~model) begin
        failures++;
        $display("FAIL random cycle %0d rst=%b sel=%b%b: got %b/%b want %b/%b",
                 i, r, ia, ib, y_h, y_l, model, ~model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_2x4_sync.md
Name:
decoder_2x4_sync

Overview:
Registered 2-to-4 line decoder. It converts the 2-bit select {a,b} into a one-hot 4-bit code on discrete outputs y0..y3, with one cycle of latency. It is a leaf block in the decode path, driven from interface signals a/b and feeding y0..y3 back onto the same interface bundle.

Parameters:
OUT_ACTIVE_LOW, 0, when 1 the registered outputs are inverted (selected line 0, others 1). The reset value is also inverted, giving all-ones.
RESET_VAL_EN, 1, when 1 reset forces the outputs to the idle code. When 0 reset is ignored by the output register (bench/debug use only).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset
a  input  1  select MSB
b  input  1  select LSB
y0  output  1  asserted when {a,b}=2'b00
y1  output  1  asserted when {a,b}=2'b01
y2  output  1  asserted when {a,b}=2'b10
y3  output  1  asserted when {a,b}=2'b11

Interface decision:
One clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Select index sel = {a,b}. a is the MSB, b is the LSB.
- Combinational decode dec[3:0] = 4'b0001 << sel. y0=dec[0], y1=dec[1], y2=dec[2], y3=dec[3].
- Output register: on each rising clk edge with rst=0, {y3,y2,y1,y0} <= dec. With OUT_ACTIVE_LOW=1 the register loads ~dec instead.
- Latency: exactly 1 cycle. Inputs are sampled at the edge; changes between edges have no effect until the next edge.
- No glitches on outputs; all outputs are driven only from flops.
- Reset: rst=1 at a rising edge forces all y to 0, or all y to 1 when OUT_ACTIVE_LOW=1. Reset has priority over decode.
- Reset mid-operation: outputs go idle at the first edge with rst high and stay idle while rst is held. At the first edge after rst falls, outputs reflect the {a,b} sampled at that edge.
- Before the first reset edge the outputs are X. The verification bench must apply reset first.
- Invariant when out of reset: exactly one of y0..y3 is asserted (one-hot, or one-cold when active-low). Embed an assertion for this, disabled during rst.
- X/Z on a or b: outputs become X. No resolution is specified; the bench must not drive X after reset.
- No enable and no handshake: the decoder updates every cycle.

Decomposition:
- Package decoder_pkg:
  - typedef logic [1:0] dec_sel_t
  - typedef logic [3:0] dec_onehot_t
  - localparam DEC_IDLE = 4'b0000
  - function onehot_decode(dec_sel_t) returning dec_onehot_t
- Optional sub-module decoder_2x4_comb: pure combinational sel→dec. The top instantiates it and adds the output register, polarity option, reset and the one-hot assertion.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1,b=1 → y3..y0 = 0000 throughout. With OUT_ACTIVE_LOW=1 → 1111.
- Exhaustive sweep: after reset, drive {a,b}=00,01,10,11 on successive edges → one cycle later y3..y0 = 0001, 0010, 0100, 1000 respectively. A scoreboard compares each cycle against the decode function.
- Latency/sampling: change {a,b} 00→11 mid-cycle and back to 00 before the next edge → outputs stay 0001. No 1000 pulse appears.
- Reset mid-stream: {a,b}=10 steady, outputs 0100. Assert rst for one edge → 0000. Deassert → next edge 0100.
- Back-to-back: toggle {a,b} every cycle 01,10,01,10 for 16 cycles → outputs alternate 0010/0100 with 1-cycle lag. The one-hot assertion never fires.
- Random: 200 cycles of random {a,b} with random 5% rst pulses → zero scoreboard mismatches.
